// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, RV32I byte/half/word lanes.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of masking them to alignment.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state, stateNext;
  logic [3:0]            waitCnt, waitCntNext;
  logic                  accept;
  logic                  reqWrite;
  logic [2:0]            reqFunct3;
  logic [ADDR_BITS+1:0]  reqAddr;
  logic [31:0]           reqWdata;
  logic [31:0]           mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0]  wordIdx;
  logic [1:0]            byteOff;
  logic                  misaligned;
  logic                  accErr;
  logic [3:0]            wrMask;
  logic [31:0]           wrData;
  logic [31:0]           rdWord;
  logic [31:0]           ldData;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^req_addr[31:ADDR_BITS+2];

  function automatic logic isUnsupported(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [31:0] lane);
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'b0, lane[7:0]};
      3'b101:  return {16'b0, lane[15:0]};
      3'b010:  return lane;
      default: return 32'b0;
    endcase
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  assign wordIdx = reqAddr[ADDR_BITS+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                      ((reqFunct3 == 3'b010) && (reqAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Half accesses align down to the halfword; words ignore the low bits entirely.
  always_comb begin
    case (reqFunct3[1:0])
      2'b00:   byteOff = reqAddr[1:0];
      2'b01:   byteOff = {reqAddr[1], 1'b0};
      default: byteOff = 2'b00;
    endcase
  end

  // State register, wait counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      req_ready  <= (stateNext == IDLE);
      resp_valid <= (stateNext == RESP);
      if (state == ACCESS) begin
        resp_rdata <= ldData;
        resp_err   <= accErr;
      end else if (state == RESP) begin
        resp_err   <= 1'b0;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            stateNext   = WAIT;
            waitCntNext = WAIT_INIT;
          end else begin
            stateNext   = ACCESS;
          end
        end
      end
      WAIT: begin
        waitCntNext = waitCnt - 4'd1;
        if (waitCnt == 4'd1) stateNext = ACCESS;
      end
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    accErr = isUnsupported(reqFunct3) || misaligned;
    rdWord = mem[wordIdx];
    case (reqFunct3[1:0])
      2'b00: begin
        wrMask = 4'b0001 << byteOff;
        wrData = {4{reqWdata[7:0]}};
      end
      2'b01: begin
        wrMask = byteOff[1] ? 4'b1100 : 4'b0011;
        wrData = {2{reqWdata[15:0]}};
      end
      default: begin
        wrMask = 4'b1111;
        wrData = reqWdata;
      end
    endcase
    if (accErr || !reqWrite || (state != ACCESS)) wrMask = 4'b0000;
    if (accErr || reqWrite) ldData = 32'b0;
    else                    ldData = extendLoad(reqFunct3, rdWord >> {byteOff, 3'b000});
  end

  // Request capture and array: data-only storage, never reset
  always_ff @(posedge clk) begin
    if (accept) begin
      reqWrite  <= req_write;
      reqFunct3 <= req_funct3;
      reqAddr   <= req_addr[ADDR_BITS+1:0];
      reqWdata  <= req_wdata;
    end
    for (int i = 0; i < 4; i++) begin
      if (wrMask[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mb [4*DEPTH];

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_BITS  (8),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic checkBit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size/sign from funct3, plain arithmetic extension.
  task automatic modelAccess(input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wd, output bit [31:0] rd, output bit er);
    int size;
    bit sgn;
    int base;
    longint val;
    rd = '0; er = 1'b0; size = 0; sgn = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: er = 1'b1;
    endcase
    if (er) return;
    base = int'(addr % (4 * DEPTH));
    if (base % size != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      base = base - (base % size);
`endif
    end
    if (wr) begin
      for (int i = 0; i < size; i++) mb[base+i] = wd[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(mb[base+i]) << (8*i));
      if (sgn && val >= (longint'(1) << (8*size-1))) val = val - (longint'(1) << (8*size));
      rd = val[31:0];
    end
  endtask

  // Compare process: checks handshake, response timing and data on every cycle.
  initial begin : cmp
    int cyc;
    bit accNext, pWr, expErr;
    bit [2:0] pF3;
    bit [31:0] pAddr, pWd, expRd, lastRd;
    cyc = 0; accNext = 1'b0; pWr = 1'b0; pF3 = '0; pAddr = '0; pWd = '0;
    expRd = '0; expErr = 1'b0; lastRd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; accNext = 1'b0; lastRd = '0;
        checkBit("rst_ready", req_ready, 1'b1);
        checkBit("rst_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        checkBit("rst_err", resp_err, 1'b0);
      end else begin
        if (accNext) cyc = 1;
        else if (cyc == W + 2) cyc = 0;
        else if (cyc > 0) cyc++;
        if (cyc == W + 1) modelAccess(pWr, pF3, pAddr, pWd, expRd, expErr);
        checkBit("ready", req_ready, cyc == 0);
        checkBit("valid", resp_valid, cyc == W + 2);
        if (cyc == W + 2) begin
          lastRd = expRd;
          checkBit("err", resp_err, expErr);
        end else begin
          checkBit("err_idle", resp_err, 1'b0);
        end
        check("rdata", resp_rdata, lastRd);
        accNext = 1'b0;
        if (req_valid && cyc == 0) begin
          accNext = 1'b1;
          pWr = req_write; pF3 = req_funct3; pAddr = req_addr; pWd = req_wdata;
        end
      end
    end
  end

  task automatic doReq(input bit wr, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                       output bit [31:0] rd, output bit er, output int lat);
    int n;
    n = 0; rd = '0; er = 1'b0; lat = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL ready_timeout: actual=0 required=1");
    end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = k;
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL resp_timeout: actual=none required=resp_valid");
    end
    @(posedge clk); #1;
  endtask

  task automatic ld(input string nm, input bit [2:0] f3, input bit [31:0] addr,
                    input bit [31:0] expRd, input bit expErr);
    bit [31:0] rd;
    bit er;
    int lat;
    doReq(1'b0, f3, addr, 32'h0, rd, er, lat);
    check(nm, rd, expRd);
    checkBit({nm, "_err"}, er, expErr);
  endtask

  task automatic st(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
    bit [31:0] rd;
    bit er;
    int lat;
    doReq(1'b1, f3, addr, wd, rd, er, lat);
  endtask

  initial begin : main
    bit [31:0] rd;
    bit er;
    int lat;
    bit sawResp;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    checkBit("ready_after_rst", req_ready, 1'b1);

    for (int i = 0; i < DEPTH; i++) st(3'b010, 32'(i * 4), $urandom);
    st(3'b010, 32'h20, 32'h0);

    doReq(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("t1_st_lat", 32'(lat), 32'd4);
    check("t1_st_rdata", rd, 32'h0);
    doReq(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("t1_lw_lat", 32'(lat), 32'd4);
    check("t1_lw", rd, 32'hDEADBEEF);

    st(3'b000, 32'h11, 32'h0000_0080);
    ld("t2_lb",  3'b000, 32'h11, 32'hFFFF_FF80, 1'b0);
    ld("t2_lbu", 3'b100, 32'h11, 32'h0000_0080, 1'b0);
    ld("t2_lw",  3'b010, 32'h10, 32'hDEAD_80EF, 1'b0);

    st(3'b001, 32'h12, 32'h0000_8001);
    ld("t3_lh",  3'b001, 32'h12, 32'hFFFF_8001, 1'b0);
    ld("t3_lhu", 3'b101, 32'h12, 32'h0000_8001, 1'b0);
    ld("t3_lw",  3'b010, 32'h10, 32'h8001_80EF, 1'b0);

    st(3'b010, 32'h400, 32'h1234_5678);
    ld("t4_wrap", 3'b010, 32'h0, 32'h1234_5678, 1'b0);
    ld("t4_f3_011", 3'b011, 32'h0, 32'h0, 1'b1);
    ld("t4_f3_111", 3'b111, 32'h10, 32'h0, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
    ld("t5_misalign", 3'b010, 32'h13, 32'h0, 1'b1);
`else
    ld("t5_misalign", 3'b010, 32'h13, 32'h8001_80EF, 1'b0);
`endif

    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkBit("t6_busy", req_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkBit("t6_ready", req_ready, 1'b1);
    sawResp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) sawResp = 1'b1;
    end
    checkBit("t6_noresp", sawResp, 1'b0);
    @(posedge clk); #1;
    ld("t6_lw", 3'b010, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      doReq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 2047)),
            $urandom, rd, er, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
